cpu_fetch: RTL and testbench

CPU_FETCH -- requirements
Module: cpu_fetch

---
 rtl/cpu_fetch_pkg.sv | 44 ++++
 rtl/cpu_fetch.sv | 124 ++++++++++++
 tb/tb_cpu_fetch.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared cpu definitions: opcode set, fetch geometry, fetch FSM states
package cpu_fetch_pkg;

    // Opcode set understood by the decode/exec stage.
    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_SUB  = 8'h02,
        OP_LD   = 8'h03,
        OP_ST   = 8'h04,
        OP_JMP  = 8'h05,
        OP_JZ   = 8'h06,
        OP_HALT = 8'hFF
    } opcode_t;

    // One instruction is three consecutive 32-bit words: opcode, opa, opb.
    localparam int unsigned FETCH_STEP_SIZE = 12;
    localparam int unsigned OFS_OPCODE      = 0;
    localparam int unsigned OFS_OPA         = 4;
    localparam int unsigned OFS_OPB         = 8;

    // Word index within the instruction being fetched.
    localparam logic [1:0] IDX_OPCODE = 2'd0;
    localparam logic [1:0] IDX_OPA    = 2'd1;
    localparam logic [1:0] IDX_OPB    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2,
        ST_WAIT = 2'd3
    } fetch_state_t;

    // Byte offset of a word index relative to the instruction's pc.
    function automatic logic [31:0] word_offset(input logic [1:0] idx);
        case (idx)
            IDX_OPCODE: return OFS_OPCODE;
            IDX_OPA:    return OFS_OPA;
            IDX_OPB:    return OFS_OPB;
            default:    return OFS_OPCODE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - three-word instruction fetch FSM with jump and wrap-around pc update
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                fetch permitted
//   mem_req_o, mem_addr_o   one read request per word, held until acked
//   mem_ack_i, mem_rdata_i  read response, only honoured while a request is pending
//   opcode_o, opa_o, opb_o  fetched instruction words
//   fetch_done_o            one-cycle pulse when all three words are valid
//   exec_done_i             exec stage finished the current instruction
//   isjcc_i, newpc_i        jump flag and target, sampled with exec_done_i
//   pc_o                    address of the instruction being fetched/executed
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(FETCH_STEP_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic [WIDTH-1:0] opcode_o,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic             fetch_done_o,
    input  logic             exec_done_i,
    input  logic             isjcc_i,
    input  logic [WIDTH-1:0] newpc_i,
    output logic [WIDTH-1:0] pc_o
);

    fetch_state_t     state;
    logic [1:0]       idx;
    logic [WIDTH-1:0] next_pc;

    // Wraps naturally at 2^WIDTH.
    assign next_pc = isjcc_i ? newpc_i : pc_o + STEP;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            idx          <= IDX_OPCODE;
            pc_o         <= RESET_PC;
            opcode_o     <= '0;
            opa_o        <= '0;
            opb_o        <= '0;
            fetch_done_o <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= RESET_PC;
        end else begin
            fetch_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_req_o <= 1'b0;
                    if (enable_i) begin
                        state      <= ST_READ;
                        idx        <= IDX_OPCODE;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc_o;
                    end
                end

                // enable_i is deliberately not looked at here: a started
                // instruction always runs to completion.
                ST_READ: begin
                    if (mem_req_o) begin
                        if (mem_ack_i) begin
                            // Drop the request for one cycle so every word
                            // is its own request/ack handshake.
                            mem_req_o <= 1'b0;
                            case (idx)
                                IDX_OPCODE: opcode_o <= mem_rdata_i;
                                IDX_OPA:    opa_o    <= mem_rdata_i;
                                IDX_OPB:    opb_o    <= mem_rdata_i;
                                default:    ;
                            endcase
                            if (idx == IDX_OPB) begin
                                state        <= ST_DONE;
                                idx          <= IDX_OPCODE;
                                fetch_done_o <= 1'b1;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                    end else begin
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc_o + WIDTH'(word_offset(idx));
                    end
                end

                // exec_done_i is not sampled in DONE, so WAIT can only be
                // left from the cycle after the fetch_done pulse onward.
                ST_DONE: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (exec_done_i) begin
                        pc_o       <= next_pc;
                        mem_addr_o <= next_pc;
                        idx        <= IDX_OPCODE;
                        if (enable_i) begin
                            state     <= ST_READ;
                            mem_req_o <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - self-checking bench for cpu_fetch with randomized memory timing and jumps
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] opcode_o, opa_o, opb_o;
    logic        fetch_done_o;
    logic        exec_done_i = 1'b0;
    logic        isjcc_i = 1'b0;
    logic [31:0] newpc_i = '0;
    logic [31:0] pc_o;

    // Memory side: auto responder or manually driven ack.
    logic        mem_auto = 1'b1;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;
    int          delay = 0;
    int          stable_err = 0;
    int          done_cnt = 0;
    int          last_lat = 0;
    logic [31:0] log_addr [$];

    int checks = 0;
    int errors = 0;

    assign mem_ack_i   = mem_auto ? auto_ack   : man_ack;
    assign mem_rdata_i = mem_auto ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    cpu_fetch dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .opcode_o     (opcode_o),
        .opa_o        (opa_o),
        .opb_o        (opb_o),
        .fetch_done_o (fetch_done_o),
        .exec_done_i  (exec_done_i),
        .isjcc_i      (isjcc_i),
        .newpc_i      (newpc_i),
        .pc_o         (pc_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0000_0000;
        if (a == 32'd4) return 32'h0000_0003;
        if (a == 32'd8) return 32'h0000_0004;
        return (a * 32'h9E37_79B9) ^ 32'h0000_A5A5;
    endfunction

    // Memory responder: ack arrives 'delay' cycles after the cycle following
    // the request rise; address must not move while the request is pending.
    initial begin
        int          cnt;
        bit          have;
        logic [31:0] held;
        cnt = 0;
        have = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_i || !mem_auto) begin
                auto_ack = 1'b0;
                cnt = 0;
                have = 1'b0;
            end else if (auto_ack) begin
                auto_ack = 1'b0;
                cnt = 0;
                have = 1'b0;
            end else if (mem_req_o) begin
                if (!have) begin
                    have = 1'b1;
                    held = mem_addr_o;
                end else if (mem_addr_o !== held) begin
                    stable_err++;
                end
                if (cnt >= delay + 1) begin
                    auto_ack = 1'b1;
                    auto_rdata = mem_word(mem_addr_o);
                    log_addr.push_back(mem_addr_o);
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fetch_done_o === 1'b1) done_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b1;
        enable_i = 1'b0;
        exec_done_i = 1'b0;
        isjcc_i = 1'b0;
        man_ack = 1'b0;
        mem_auto = 1'b1;
        delay = 0;
        repeat (2) @(negedge clk);
        log_addr.delete();
        stable_err = 0;
        done_cnt = 0;
        rst_i = 1'b0;
    endtask

    task automatic wait_req(output bit to);
        int n;
        n = 0;
        to = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_req_o !== 1'b1 && n < 100);
        if (mem_req_o !== 1'b1) to = 1'b1;
    endtask

    // Returns on the negedge where fetch_done_o is seen; last_lat counts the
    // cycles strictly between the call and that cycle.
    task automatic wait_done(output bit to);
        bit seen;
        seen = 1'b0;
        to = 1'b0;
        last_lat = 0;
        while (!seen && !to) begin
            @(negedge clk);
            if (fetch_done_o === 1'b1) seen = 1'b1;
            else begin
                last_lat++;
                if (last_lat > 200) to = 1'b1;
            end
        end
    endtask

    // Called on the fetch_done negedge; exec_done is raised one cycle later.
    task automatic do_exec(input bit jmp, input logic [31:0] tgt);
        @(negedge clk);
        isjcc_i = jmp;
        newpc_i = tgt;
        exec_done_i = 1'b1;
        log_addr.delete();
        @(negedge clk);
        exec_done_i = 1'b0;
        isjcc_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_i = 1'b1;
        enable_i = 1'b1;
        exec_done_i = 1'b1;
        isjcc_i = 1'b1;
        newpc_i = 32'h1234_5678;
        mem_auto = 1'b0;
        man_ack = 1'b1;
        man_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
        checks++; if ({opcode_o, opa_o, opb_o} !== 96'h0) begin errors++; $display("FAIL reset_words got %h %h %h want 0", opcode_o, opa_o, opb_o); end
        checks++; if (fetch_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", fetch_done_o); end
        exec_done_i = 1'b0;
        isjcc_i = 1'b0;
        man_ack = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        apply_reset();
        enable_i = 1'b1;
        wait_req(to);
        checks++; if (to) begin errors++; $display("FAIL basic_req_timeout got none want request"); return; end
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL basic_done_timeout got none want pulse"); return; end
        checks++; if (last_lat != 7) begin errors++; $display("FAIL basic_latency got %0d want 7", last_lat); end
        checks++; if (log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'd0, 32'd4, 32'd8})
            begin errors++; $display("FAIL basic_addrs got %p want 0,4,8", log_addr); end
        checks++; if ({opcode_o, opa_o, opb_o} !== {32'd0, 32'd3, 32'd4})
            begin errors++; $display("FAIL basic_words got %h %h %h want 0 3 4", opcode_o, opa_o, opb_o); end
        @(negedge clk);
        checks++; if (fetch_done_o !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %0b want 0", fetch_done_o); end
        do_exec(1'b0, 32'h0);
        checks++; if (pc_o !== 32'd12) begin errors++; $display("FAIL basic_pc got %h want c", pc_o); end
    endtask

    task automatic test_slow_mem();
        bit to;
        apply_reset();
        delay = 3;
        enable_i = 1'b1;
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL slow_done_timeout got none want pulse"); return; end
        checks++; if (log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'd0, 32'd4, 32'd8})
            begin errors++; $display("FAIL slow_addrs got %p want 0,4,8", log_addr); end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL slow_addr_stable got %0d moves want 0", stable_err); end
        repeat (6) @(negedge clk);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL slow_one_pulse got %0d want 1", done_cnt); end
        checks++; if ({opcode_o, opa_o, opb_o} !== {32'd0, 32'd3, 32'd4})
            begin errors++; $display("FAIL slow_words_hold got %h %h %h want 0 3 4", opcode_o, opa_o, opb_o); end
    endtask

    task automatic test_jump();
        bit to;
        apply_reset();
        enable_i = 1'b1;
        wait_done(to);
        do_exec(1'b1, 32'h40);
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL jump_pc got %h want 40", pc_o); end
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL jump_done_timeout got none want pulse"); return; end
        checks++; if (log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'h40, 32'h44, 32'h48})
            begin errors++; $display("FAIL jump_addrs got %p want 40,44,48", log_addr); end
        checks++; if ({opcode_o, opa_o, opb_o} !== {mem_word(32'h40), mem_word(32'h44), mem_word(32'h48)})
            begin errors++; $display("FAIL jump_words got %h %h %h", opcode_o, opa_o, opb_o); end
    endtask

    task automatic test_wrap();
        bit to;
        apply_reset();
        enable_i = 1'b1;
        wait_done(to);
        do_exec(1'b1, 32'hFFFF_FFF4);
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL wrap_done_timeout got none want pulse"); return; end
        checks++; if (log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC})
            begin errors++; $display("FAIL wrap_addrs got %p want fffffff4,fffffff8,fffffffc", log_addr); end
        do_exec(1'b0, 32'h0);
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc_o); end
        wait_done(to);
        checks++; if (log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'd0, 32'd4, 32'd8})
            begin errors++; $display("FAIL wrap_next_addrs got %p want 0,4,8", log_addr); end
    endtask

    task automatic test_enable_drop();
        bit to;
        int n;
        int reqs;
        apply_reset();
        enable_i = 1'b1;
        n = 0;
        while (log_addr.size() < 1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        enable_i = 1'b0;
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL endrop_done_timeout got none want pulse"); return; end
        checks++; if ({opcode_o, opa_o, opb_o} !== {32'd0, 32'd3, 32'd4})
            begin errors++; $display("FAIL endrop_words got %h %h %h want 0 3 4", opcode_o, opa_o, opb_o); end
        do_exec(1'b0, 32'h0);
        checks++; if (pc_o !== 32'd12) begin errors++; $display("FAIL endrop_pc got %h want c", pc_o); end
        reqs = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_req_o !== 1'b0) reqs++;
        end
        checks++; if (reqs != 0) begin errors++; $display("FAIL endrop_idle_req got %0d cycles want 0", reqs); end
        enable_i = 1'b1;
        wait_done(to);
        checks++; if (log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'd12, 32'd16, 32'd20})
            begin errors++; $display("FAIL endrop_resume_addrs got %p want c,10,14", log_addr); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        apply_reset();
        enable_i = 1'b1;
        wait_done(to);
        do_exec(1'b1, 32'h100);
        n = 0;
        while (log_addr.size() < 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        mem_auto = 1'b0;
        wait_req(to);
        checks++; if (to || mem_addr_o !== 32'h108) begin errors++; $display("FAIL rstmid_pending got %h want 108", mem_addr_o); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0b want 0", mem_req_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %h want 0", pc_o); end
        enable_i = 1'b0;
        man_rdata = 32'hDEAD_BEEF;
        man_ack = 1'b1;
        repeat (3) @(negedge clk);
        man_ack = 1'b0;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_no_pulse got %0d want 1", done_cnt); end
        checks++; if ({opcode_o, opa_o, opb_o} !== 96'h0 || mem_req_o !== 1'b0)
            begin errors++; $display("FAIL rstmid_stale got %h %h %h req %0b want 0", opcode_o, opa_o, opb_o, mem_req_o); end
        log_addr.delete();
        mem_auto = 1'b1;
        enable_i = 1'b1;
        wait_done(to);
        checks++; if (to || log_addr.size() != 3 || {log_addr[0], log_addr[1], log_addr[2]} !== {32'd0, 32'd4, 32'd8})
            begin errors++; $display("FAIL rstmid_restart got %p want 0,4,8", log_addr); end
    endtask

    task automatic test_random();
        bit          to;
        bit          jmp;
        bit          early;
        int          waitc;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] nxt;
        apply_reset();
        enable_i = 1'b1;
        exp_pc = 32'h0;
        for (int n = 0; n < 20; n++) begin
            wait_done(to);
            checks++; if (to) begin errors++; $display("FAIL rand_done_timeout instr %0d", n); return; end
            checks++; if (log_addr.size() != 3 ||
                          {log_addr[0], log_addr[1], log_addr[2]} !== {exp_pc, exp_pc + 32'd4, exp_pc + 32'd8})
                begin errors++; $display("FAIL rand_addrs instr %0d got %p want base %h", n, log_addr, exp_pc); end
            checks++; if ({opcode_o, opa_o, opb_o} !== {mem_word(exp_pc), mem_word(exp_pc + 32'd4), mem_word(exp_pc + 32'd8)})
                begin errors++; $display("FAIL rand_words instr %0d got %h %h %h", n, opcode_o, opa_o, opb_o); end
            jmp   = ($urandom_range(0, 3) == 0);
            tgt   = $urandom;
            early = ($urandom_range(0, 2) == 0);
            waitc = $urandom_range(0, 2);
            nxt   = jmp ? tgt : exp_pc + 32'd12;
            isjcc_i = jmp;
            newpc_i = tgt;
            delay = $urandom_range(0, 3);
            if (early) begin
                exec_done_i = 1'b1;
                @(negedge clk);
                checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL rand_early_exit instr %0d got %h want %h", n, pc_o, exp_pc); end
                log_addr.delete();
                @(negedge clk);
            end else begin
                repeat (waitc + 1) @(negedge clk);
                exec_done_i = 1'b1;
                log_addr.delete();
                @(negedge clk);
            end
            exec_done_i = 1'b0;
            checks++; if (pc_o !== nxt) begin errors++; $display("FAIL rand_pc instr %0d got %h want %h", n, pc_o, nxt); end
            exp_pc = nxt;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_mem();
        test_jump();
        test_wrap();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
